// File: rtl/esc_trip_pkg.sv
// Shared definitions for the ESC trip logic: cause-bit layout, UV arming states
// and the sticky cause-register update rule.
package esc_trip_pkg;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_OC   = 0;
  localparam int CAUSE_OV   = 1;
  localparam int CAUSE_UV   = 2;
  localparam int CAUSE_COMP = 3;

  typedef enum logic {
    UV_DISARMED = 1'b0,
    UV_ARMED    = 1'b1
  } uv_state_e;

  // A condition that is active wins over a simultaneous clear request.
  function automatic logic [CAUSE_W-1:0] next_cause(
    input logic [CAUSE_W-1:0] cur,
    input logic [CAUSE_W-1:0] active,
    input logic               clr
  );
    return clr ? active : (cur | active);
  endfunction

endpackage

// File: rtl/fault_trip_detect_if.sv
// Sample/limit inputs and trip outputs of fault_trip_detect grouped as one bundle.
// The master side drives samples and limits; the slave side (the detector) drives the trip outputs.
interface fault_trip_detect_if
  import esc_trip_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 4
);
  logic               s_valid;
  logic [DATA_W-1:0]  i_mag;
  logic [DATA_W-1:0]  v_bus;
  logic [DATA_W-1:0]  oc_limit;
  logic [DATA_W-1:0]  ov_limit;
  logic [DATA_W-1:0]  uv_limit;
  logic [CNT_W-1:0]   filt_count;
  logic               comp_n;
  logic               clear_cause;
  logic               trip_src;
  logic [CAUSE_W-1:0] trip_cause;

  modport master (
    output s_valid, i_mag, v_bus, oc_limit, ov_limit, uv_limit,
           filt_count, comp_n, clear_cause,
    input  trip_src, trip_cause
  );

  modport slave (
    input  s_valid, i_mag, v_bus, oc_limit, ov_limit, uv_limit,
           filt_count, comp_n, clear_cause,
    output trip_src, trip_cause
  );
endinterface

// File: rtl/trip_filt_cnt.sv
// Saturating consecutive-violation counter; active once the count reaches the
// threshold, where a threshold of 0 behaves as 1.
module trip_filt_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_ctrl,
  input  logic             rst_ctrl_n,
  input  logic             i_hold_zero,
  input  logic             i_en,
  input  logic             i_viol,
  input  logic [CNT_W-1:0] i_thresh,
  output logic             o_active
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_thresh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_ctrl) begin
    if (!rst_ctrl_n || i_hold_zero) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (!i_viol)               r_cnt <= '0;
      else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Threshold is compared live, so a filter change applies without touching the count.
  assign w_thresh = (i_thresh == '0) ? CNT_ONE : i_thresh;
  assign o_active = (r_cnt >= w_thresh);

endmodule

// File: rtl/fault_trip_detect.sv
// Filtered OC / OV / UV / external-comparator trip detector with sticky causes.
// Define TRIP_BUS_CHECK_EN to build the DC-bus OV/UV checks; otherwise those inputs are ignored.
module fault_trip_detect
  import esc_trip_pkg::*;
#(
  parameter int DATA_W    = 12,
  parameter int CNT_W     = 4,
  parameter int COMP_FILT = 3
) (
  input logic                clk_ctrl,
  input logic                rst_ctrl_n,
  fault_trip_detect_if.slave bus
);
  logic [CAUSE_W-1:0] w_active;
  logic               w_comp_cnt_hit;
  logic               r_comp_s1;
  logic               r_comp_s2;
  logic               r_trip_src;
  logic [CAUSE_W-1:0] r_trip_cause;

  trip_filt_cnt #(.CNT_W(CNT_W)) u_oc_filt (
    .clk_ctrl    (clk_ctrl),
    .rst_ctrl_n  (rst_ctrl_n),
    .i_hold_zero (1'b0),
    .i_en        (bus.s_valid),
    .i_viol      (bus.i_mag > bus.oc_limit),
    .i_thresh    (bus.filt_count),
    .o_active    (w_active[CAUSE_OC])
  );

  // Synchroniser idles high so reset never looks like a comparator trip.
  always_ff @(posedge clk_ctrl) begin
    if (!rst_ctrl_n) begin
      r_comp_s1 <= 1'b1;
      r_comp_s2 <= 1'b1;
    end else begin
      r_comp_s1 <= bus.comp_n;
      r_comp_s2 <= r_comp_s1;
    end
  end

  trip_filt_cnt #(.CNT_W(CNT_W)) u_comp_filt (
    .clk_ctrl    (clk_ctrl),
    .rst_ctrl_n  (rst_ctrl_n),
    .i_hold_zero (1'b0),
    .i_en        (1'b1),
    .i_viol      (!r_comp_s2),
    .i_thresh    (CNT_W'(COMP_FILT)),
    .o_active    (w_comp_cnt_hit)
  );

  assign w_active[CAUSE_COMP] = w_comp_cnt_hit & ~r_comp_s2;

`ifdef TRIP_BUS_CHECK_EN
  uv_state_e r_uv_state;
  uv_state_e w_uv_state_nxt;

  always_ff @(posedge clk_ctrl) begin
    if (!rst_ctrl_n) r_uv_state <= UV_DISARMED;
    else             r_uv_state <= w_uv_state_nxt;
  end

  // NOTE: the default assignment comes first so no path leaves the next state
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_uv_state_nxt = r_uv_state;
    case (r_uv_state)
      UV_DISARMED: if (bus.s_valid && (bus.v_bus >= bus.uv_limit)) w_uv_state_nxt = UV_ARMED;
      UV_ARMED:    w_uv_state_nxt = UV_ARMED;
    endcase
  end

  trip_filt_cnt #(.CNT_W(CNT_W)) u_ov_filt (
    .clk_ctrl    (clk_ctrl),
    .rst_ctrl_n  (rst_ctrl_n),
    .i_hold_zero (1'b0),
    .i_en        (bus.s_valid),
    .i_viol      (bus.v_bus > bus.ov_limit),
    .i_thresh    (bus.filt_count),
    .o_active    (w_active[CAUSE_OV])
  );

  // UV stays quiet until the bus has been seen healthy once (power-up ramp).
  trip_filt_cnt #(.CNT_W(CNT_W)) u_uv_filt (
    .clk_ctrl    (clk_ctrl),
    .rst_ctrl_n  (rst_ctrl_n),
    .i_hold_zero (r_uv_state == UV_DISARMED),
    .i_en        (bus.s_valid),
    .i_viol      (bus.v_bus < bus.uv_limit),
    .i_thresh    (bus.filt_count),
    .o_active    (w_active[CAUSE_UV])
  );
`else
  logic w_unused_bus;
  assign w_unused_bus         = ^{bus.v_bus, bus.ov_limit, bus.uv_limit};
  assign w_active[CAUSE_OV]   = 1'b0;
  assign w_active[CAUSE_UV]   = 1'b0;
`endif

  always_ff @(posedge clk_ctrl) begin
    if (!rst_ctrl_n) begin
      r_trip_src   <= 1'b0;
      r_trip_cause <= '0;
    end else begin
      r_trip_src   <= |w_active;
      r_trip_cause <= next_cause(r_trip_cause, w_active, bus.clear_cause);
    end
  end

  assign bus.trip_src   = r_trip_src;
  assign bus.trip_cause = r_trip_cause;

endmodule

// File: tb/tb_fault_trip_detect.sv
// Directed bench for fault_trip_detect: stimulus queues expected {trip_src, trip_cause}
// per cycle, an independent negedge monitor pops and compares.
module tb_fault_trip_detect;
  import esc_trip_pkg::*;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 4;
`ifdef TRIP_BUS_CHECK_EN
  localparam bit BUS_EN = 1'b1;
`else
  localparam bit BUS_EN = 1'b0;
`endif
  localparam logic [DATA_W-1:0] V_OK = 12'd2000;

  logic clk_ctrl;
  logic rst_ctrl_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  int         q_cyc[$];
  logic [4:0] q_val[$];
  string      q_name[$];

  fault_trip_detect_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fault_trip_detect #(.DATA_W(DATA_W), .CNT_W(CNT_W), .COMP_FILT(3)) dut (
    .clk_ctrl   (clk_ctrl),
    .rst_ctrl_n (rst_ctrl_n),
    .bus        (bus)
  );

  initial clk_ctrl = 1'b0;
  always #5 clk_ctrl = ~clk_ctrl;
  always @(posedge clk_ctrl) cyc <= cyc + 1;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: trip_src,cause got %b,%04b expected %b,%04b",
               name, act[4], act[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Monitor: compares DUT outputs for every expectation due this cycle.
  always @(negedge clk_ctrl) begin
    while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
      void'(q_cyc.pop_front());
      check(q_name.pop_front(), {bus.trip_src, bus.trip_cause}, q_val.pop_front());
    end
  end

  task automatic step();
    @(posedge clk_ctrl);
    #1;
  endtask

  task automatic expect_now(input string name, input logic src, input logic [3:0] cause);
    q_cyc.push_back(cyc);
    q_val.push_back({src, cause});
    q_name.push_back(name);
  endtask

  task automatic strobe(input logic [DATA_W-1:0] im, input logic [DATA_W-1:0] vb);
    bus.s_valid = 1'b1;
    bus.i_mag   = im;
    bus.v_bus   = vb;
    step();
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_cause = 1'b1;
    step();
    bus.clear_cause = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] run_vec [4];
    run_vec = '{12'd1001, 12'd1001, 12'd1000, 12'd1001};

    rst_ctrl_n      = 1'b0;
    bus.s_valid     = 1'b0;
    bus.i_mag       = '0;
    bus.v_bus       = V_OK;
    bus.oc_limit    = 12'd1000;
    bus.ov_limit    = 12'd4000;
    bus.uv_limit    = 12'd100;
    bus.filt_count  = 4'd3;
    bus.comp_n      = 1'b1;
    bus.clear_cause = 1'b0;
    step(); step();
    expect_now("reset_state", 1'b0, 4'b0000);
    rst_ctrl_n = 1'b1;
    step();

    // OC: three violating strobes, trip one cycle after the third.
    repeat (3) strobe(12'd1001, V_OK);
    expect_now("oc_latency", 1'b0, 4'b0000);
    step();
    expect_now("oc_trip", 1'b1, 4'b0001);
    pulse_clear();
    expect_now("clear_while_active", 1'b1, 4'b0001);
    strobe(12'd500, V_OK);
    expect_now("oc_release_lag", 1'b1, 4'b0001);
    step();
    expect_now("oc_released", 1'b0, 4'b0001);
    pulse_clear();
    expect_now("clear_after_release", 1'b0, 4'b0000);

    // Broken run and equality never trip.
    foreach (run_vec[i]) strobe(run_vec[i], V_OK);
    step();
    expect_now("oc_broken_run", 1'b0, 4'b0000);
    repeat (5) strobe(12'd1000, V_OK);
    step();
    expect_now("oc_equal", 1'b0, 4'b0000);

    // Count holds between strobes.
    repeat (2) strobe(12'd1001, V_OK);
    repeat (5) step();
    expect_now("oc_hold_idle", 1'b0, 4'b0000);
    strobe(12'd1001, V_OK);
    step();
    expect_now("oc_hold_trip", 1'b1, 4'b0001);
    strobe(12'd500, V_OK);
    step();
    pulse_clear();
    expect_now("clear_hold", 1'b0, 4'b0000);

    // Threshold lowered mid-count acts without clearing; 0 behaves as 1.
    repeat (2) strobe(12'd1001, V_OK);
    expect_now("filt_pre", 1'b0, 4'b0000);
    bus.filt_count = 4'd2;
    step();
    expect_now("filt_change", 1'b1, 4'b0001);
    bus.filt_count = 4'd0;
    strobe(12'd500, V_OK);
    step();
    expect_now("filt_release", 1'b0, 4'b0001);
    pulse_clear();
    strobe(12'd1001, V_OK);
    step();
    expect_now("filt_zero_as_one", 1'b1, 4'b0001);
    strobe(12'd500, V_OK);
    step();
    pulse_clear();
    expect_now("clear_filt", 1'b0, 4'b0000);

    // Counter saturates at 15 rather than wrapping.
    bus.filt_count = 4'd15;
    repeat (14) strobe(12'd1001, V_OK);
    step();
    expect_now("sat_pre", 1'b0, 4'b0000);
    strobe(12'd1001, V_OK);
    step();
    expect_now("sat_reach", 1'b1, 4'b0001);
    repeat (5) strobe(12'd1001, V_OK);
    step();
    expect_now("sat_hold", 1'b1, 4'b0001);
    strobe(12'd500, V_OK);
    step();
    pulse_clear();
    expect_now("clear_sat", 1'b0, 4'b0000);
    bus.filt_count = 4'd3;

    // Comparator glitch of two cycles is filtered out.
    bus.comp_n = 1'b0;
    step(); step();
    bus.comp_n = 1'b1;
    repeat (6) begin
      step();
      expect_now("comp_glitch", 1'b0, 4'b0000);
    end

    // Ten low cycles: 2 sync + 3 filter edges, then the output register.
    bus.comp_n = 1'b0;
    repeat (5) step();
    expect_now("comp_lag", 1'b0, 4'b0000);
    step();
    expect_now("comp_trip", 1'b1, 4'b1000);
    repeat (4) step();
    bus.comp_n = 1'b1;
    step();
    expect_now("comp_hold", 1'b1, 4'b1000);
    step(); step();
    expect_now("comp_released", 1'b0, 4'b1000);

    // Reset mid-count clears causes and discards the partial run.
    repeat (2) strobe(12'd1001, V_OK);
    rst_ctrl_n = 1'b0;
    step();
    expect_now("reset_mid", 1'b0, 4'b0000);
    rst_ctrl_n = 1'b1;
    repeat (2) strobe(12'd1001, V_OK);
    step();
    expect_now("post_reset_partial", 1'b0, 4'b0000);
    strobe(12'd1001, V_OK);
    step();
    expect_now("post_reset_full", 1'b1, 4'b0001);
    strobe(12'd500, V_OK);
    step();
    pulse_clear();

    // UV is disarmed from reset until the bus is seen at or above the limit.
    rst_ctrl_n = 1'b0;
    step();
    rst_ctrl_n = 1'b1;
    repeat (5) strobe(12'd0, 12'd50);
    step();
    expect_now("uv_disarmed", 1'b0, 4'b0000);
    strobe(12'd0, 12'd120);
    repeat (3) strobe(12'd0, 12'd100);
    step();
    expect_now("uv_equal", 1'b0, 4'b0000);
    repeat (2) strobe(12'd0, 12'd50);
    step();
    expect_now("uv_partial", 1'b0, 4'b0000);
    strobe(12'd0, 12'd50);
    expect_now("uv_lag", 1'b0, 4'b0000);
    step();
    expect_now("uv_trip", BUS_EN, BUS_EN ? 4'b0100 : 4'b0000);
    repeat (3) strobe(12'd0, 12'd4000);
    step();
    expect_now("ov_equal", 1'b0, BUS_EN ? 4'b0100 : 4'b0000);
    repeat (3) strobe(12'd0, 12'd4001);
    step();
    expect_now("ov_trip", BUS_EN, BUS_EN ? 4'b0110 : 4'b0000);

    step(); step();
    check("scoreboard_drained", 5'(q_cyc.size()), 5'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fault_trip_detect.md
FAULT_TRIP_DETECT -- requirements
Module: fault_trip_detect

Interface
REQ-001 Parameter DATA_W, 12, width of current/voltage samples and limits (unsigned).
REQ-002 Parameter CNT_W, 4, width of consecutive-sample filter counters and filt_count.
REQ-003 Parameter COMP_FILT, 3, clock cycles comp_n must stay low after synchronisation before it trips.
REQ-004 clk_ctrl  in  1  control clock; single clock domain.
REQ-005 rst_ctrl_n  in  1  synchronous, active-low reset.
REQ-006 s_valid  in  1  one-cycle strobe; i_mag and v_bus valid this cycle.
REQ-007 i_mag  in  DATA_W  phase-current magnitude sample.
REQ-008 v_bus  in  DATA_W  DC-bus voltage sample.
REQ-009 oc_limit, ov_limit, uv_limit  in  DATA_W each  quasi-static trip thresholds.
REQ-010 filt_count  in  CNT_W  consecutive violating samples required; 0 treated as 1.
REQ-011 comp_n  in  1  asynchronous external overcurrent comparator, active-low.
REQ-012 clear_cause  in  1  one-cycle pulse; clears sticky cause bits.
REQ-013 trip_src  out  1  registered level, high while any filtered condition active; feeds the PWM kill latch.
REQ-014 trip_cause  out  4  sticky bits: [0] OC, [1] OV, [2] UV, [3] COMP.

Function
REQ-015 Violations SHALL be strict: OC i_mag>oc_limit, OV v_bus>ov_limit, UV v_bus<uv_limit; equality never violates.
REQ-016 Per sample condition: on s_valid with violation, counter increments, saturating at 2^CNT_W-1; on s_valid without violation, counter clears to 0; without s_valid, counter holds.
REQ-017 Condition active while counter >= max(filt_count,1).
REQ-018 UV check SHALL use a two-state FSM: DISARMED (UV counter held 0) -> ARMED on first s_valid with v_bus>=uv_limit; ARMED holds until reset.
REQ-019 comp_n SHALL pass a 2-FF synchroniser, then a counter requiring COMP_FILT consecutive low cycles; any high cycle clears it; COMP active while count reached and input low.
REQ-020 trip_src SHALL rise one cycle after the s_valid edge at which a counter reaches threshold; COMP trip at 2+COMP_FILT cycles after comp_n falls (±1 for async capture).
REQ-021 trip_src SHALL fall one cycle after all conditions inactive.
REQ-022 trip_cause bits set in the same cycle trip_src rises for that condition; set takes priority over clear_cause in the same cycle.
REQ-023 filt_count change mid-count SHALL apply to the next comparison without clearing counters.

Reset
REQ-024 On rst_ctrl_n low at a clk_ctrl edge: trip_src=0, trip_cause=0, all counters 0, UV FSM DISARMED, synchroniser flops=1 (inactive).
REQ-025 Reset asserted mid-filter SHALL discard partial counts; first post-reset trip requires a full filter run.

Configuration
REQ-026 Macro TRIP_BUS_CHECK_EN defined: OV/UV logic and UV FSM built as above.
REQ-027 Macro undefined: v_bus, ov_limit, uv_limit ports remain but are ignored; trip_cause[2:1] tied 0; OC and COMP unaffected.

Structure
REQ-028 Shared package esc_trip_pkg SHALL hold cause-bit index constants (CAUSE_OC=0, CAUSE_OV=1, CAUSE_UV=2, CAUSE_COMP=3) and cause-vector width 4.
REQ-029 Sub-module trip_filt_cnt (saturating consecutive-violation counter with threshold compare) SHALL be instantiated per sample condition.

Verification
REQ-030 filt_count=3, oc_limit=1000, i_mag=1001 on three s_valid -> trip_src high cycle after third strobe, trip_cause=4'b0001.
REQ-031 i_mag=1001,1001,1000,1001 with filt_count=3 -> no trip; i_mag=1000 alone never trips.
REQ-032 v_bus=50 < uv_limit=100 from reset -> no trip; then v_bus=120, then 50 for filt_count strobes -> trip_cause[2]=1.
REQ-033 comp_n low 2 cycles then high -> no trip; low 10 cycles -> trip_src high after 2+COMP_FILT cycles, trip_cause[3]=1.
REQ-034 clear_cause pulsed with OC still active -> trip_cause[0] stays 1; after condition clears, pulse -> 0; rst_ctrl_n low mid-count -> all outputs 0.
